// File: rtl/demux4_reg_if.sv
// Handshake bundle for demux4_reg: one input port plus four valid/ready output channels.
// The master modport is the sender/consumer side, slave is the demultiplexer itself.
interface demux4_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel1;
  logic             sel2;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [CNT_W-1:0] acc_count;

  modport master (
    output in_valid, in_data, sel1, sel2, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, acc_count
  );

  modport slave (
    input  in_valid, in_data, sel1, sel2, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, acc_count
  );
endinterface

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer: steers a word to one of four one-entry output
// channels selected by {sel1,sel2}, with per-channel valid/ready backpressure.
module demux4_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  demux4_reg_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        state_q [4];
  ch_state_e        state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [1:0] idx;
  logic       accept;

  assign idx    = {bus.sel1, bus.sel2};
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < 4; n++) begin
        state_q[n] <= EMPTY;
        data_q[n]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        data_q[n]  <= data_d[n];
      end
      cnt_q <= cnt_d;
    end
  end

  // A load into a channel takes priority over its drain, so a channel whose
  // consumer stays ready can be refilled every cycle without a bubble.
  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      data_d[n]  = data_q[n];
      if (accept && (idx == n[1:0])) begin
        state_d[n] = FULL;
        data_d[n]  = bus.in_data;
      end else if ((state_q[n] == FULL) && bus.out_ready[n]) begin
        state_d[n] = EMPTY;
      end
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};
  end

  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      bus.out_valid[n] = (state_q[n] == FULL);
    end
    bus.in_ready  = (state_q[idx] == EMPTY) || bus.out_ready[idx];
    bus.out_data0 = data_q[0];
    bus.out_data1 = data_q[1];
    bus.out_data2 = data_q[2];
    bus.out_data3 = data_q[3];
    bus.acc_count = cnt_q;
  end

endmodule

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the write-side counterpart of the 4:1 select mux.
- Accepts a data word with a 2-bit destination select and routes it into one of four output channels.
- Each output channel has a one-entry holding register and a valid/ready handshake.
- Used to steer results (e.g. write-back or forwarding data) into four consumer paths, with backpressure per destination.

Parameters:
WIDTH, 32, data width of the input word and of each output channel
CNT_W, 8, width of the accepted-transaction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept the word addressed by the current sel1/sel2
in_data  input  WIDTH  input word
sel1  input  1  destination select, MSB
sel2  input  1  destination select, LSB
out_valid  output  4  per-channel valid; bit n = channel n
out_ready  input  4  per-channel consumer ready; bit n = channel n
out_data0  output  WIDTH  channel 0 data
out_data1  output  WIDTH  channel 1 data
out_data2  output  WIDTH  channel 2 data
out_data3  output  WIDTH  channel 3 data
acc_count  output  CNT_W  number of accepted input words, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=4'b0000, all out_dataN=0, acc_count=0. These apply immediately on rst_n low, with no clock needed.
- Destination index: idx={sel1,sel2}. 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- Per-channel state: one of two states, EMPTY (out_valid[n]=0) or FULL (out_valid[n]=1).
- in_ready (combinational): in_ready = !out_valid[idx] || out_ready[idx].
  - It depends only on idx and on the state and ready of the addressed channel.
  - It must not depend on in_valid.
- Accept: on a clk edge where in_valid && in_ready:
  - out_data{idx} <= in_data
  - out_valid[idx] <= 1
  - acc_count <= acc_count+1
  - Latency: the word is visible on out_data{idx} with out_valid set one cycle after acceptance.
- Drain: on a clk edge where out_valid[n] && out_ready[n] and there is no accept into channel n, out_valid[n] <= 0.
- Simultaneous drain and accept on the same channel:
  - out_valid stays 1 and out_data is replaced by the new word.
  - This gives full throughput of one word per cycle to a single channel whose consumer holds out_ready high.
- Independent channels: drains on other channels in the same cycle proceed regardless of which channel is being loaded. Only one channel can be loaded per cycle.
- Backpressure:
  - If channel idx is FULL and out_ready[idx]=0, then in_ready=0. The word is not accepted and nothing changes.
  - Words for other channels are not blocked by a stalled channel once sel changes.
- Sender obligation: in_data, sel1 and sel2 must be held stable while in_valid=1 and in_ready=0. The block does not check this.
- Data hold: out_dataN keeps its last value when out_valid[n]=0. It is not cleared on drain.
- out_ready[n] while out_valid[n]=0 is ignored.
- acc_count wraps from 2^CNT_W-1 to 0 with no flag.
- in_valid=0: no state change except drains.
- Reset mid-operation: all FULL channels are discarded (out_valid→0, data→0). Handshakes in flight are lost. The first accept after rst_n deasserts is counted as 1.
- All outputs except in_ready are registered.

Test Plan:
- Reset, then send 0xA5A5A5A5 with sel=10 and out_ready=4'b0000 → in_ready=1. Next cycle out_valid=4'b0100, out_data2=0xA5A5A5A5, acc_count=1.
- Channel 2 FULL with out_ready[2]=0; send sel=10, data 0x1 → in_ready=0, out_data2 unchanged, acc_count unchanged. Raise out_ready[2] → accepted the same cycle; out_data2=0x1 next cycle with out_valid[2] still 1.
- Channel 2 stalled FULL; send sel=00, data 0x77 → accepted. out_valid=4'b0101, out_data0=0x77.
- out_ready[3]=1 held; stream 8 consecutive words 1..8 to sel=11 → in_ready stays 1. out_data3 shows 1..8 on consecutive cycles, acc_count=8.
- Preload acc_count to 255 (CNT_W=8) via 255 accepts; one more accept → acc_count=0.
- Fill all four channels with out_ready=0, then assert rst_n=0 asynchronously between clock edges → out_valid=0 and all out_dataN=0 immediately, without a clock edge; acc_count=0.
